// File: rtl/risc16_pkg.sv
// Shared constants for the 16-bit RISC datapath: ALU opcodes, write-source
// selects and register-file geometry.
package risc16_pkg;

    localparam int unsigned NumRegs  = 16;
    localparam int unsigned RegAddrW = 4;

    typedef enum logic [2:0] {
        AluAdd   = 3'b000,
        AluSub   = 3'b001,
        AluAnd   = 3'b010,
        AluOr    = 3'b011,
        AluXor   = 3'b100,
        AluNot   = 3'b101,
        AluPassA = 3'b110,
        AluPassB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        WSrcAlu  = 2'b00,
        WSrcMem  = 2'b01,
        WSrcImm  = 2'b10,
        WSrcRsvd = 2'b11
    } wsrc_e;

endpackage

// File: rtl/risc_16bit_regfile.sv
// 16 x W register file: two combinational read ports that return zero when
// disabled, one synchronous write port, asynchronous active-high clear.
module risc_16bit_regfile
    import risc16_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w_en,
    input  logic [RegAddrW-1:0] w_addr,
    input  logic [W-1:0]        w_data,
    input  logic [RegAddrW-1:0] rp_addr,
    input  logic                rp_rd,
    input  logic [RegAddrW-1:0] rq_addr,
    input  logic                rq_rd,
    output logic [W-1:0]        rp_data,
    output logic [W-1:0]        rq_data
);

    logic [W-1:0] regs [NumRegs];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs[i] <= '0;
            end
        end else if (w_en) begin
            regs[w_addr] <= w_data;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rp_data = rp_rd ? regs[rp_addr] : '0;
    assign rq_data = rq_rd ? regs[rq_addr] : '0;

endmodule

// File: rtl/risc_16bit_datapath.sv
// 16-bit RISC datapath: register file, ALU, write-source mux and data memory.
// Optional carry/overflow flags are enabled with RISC16_DP_FLAGS_EN.
module risc_16bit_datapath
    import risc16_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned AW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       D_addr,
    input  logic                D_rd,
    input  logic                D_wr,
    input  logic [AW-1:0]       RF_W_data,
    input  logic                RF_s1,
    input  logic                RF_s0,
    input  logic [RegAddrW-1:0] RF_W_addr,
    input  logic                RF_W_wr,
    input  logic [RegAddrW-1:0] RF_Rp_addr,
    input  logic                RF_Rp_rd,
    input  logic [RegAddrW-1:0] RF_Rq_addr,
    input  logic                RF_Rq_rd,
    input  logic [2:0]          alu_s,
    output logic                RF_Rp_zero,
    output logic [W-1:0]        R_data,
    output logic [W-1:0]        alu_out
`ifdef RISC16_DP_FLAGS_EN
    ,
    output logic                flag_c,
    output logic                flag_v
`endif
);

    logic [W-1:0] rp_data;
    logic [W-1:0] rq_data;
    logic [W-1:0] add_res;
    logic [W-1:0] sub_res;
    logic [W-1:0] w_data;
    logic         rf_w_en;
    wsrc_e        wsrc;
    logic [W-1:0] mem [2**AW];

    assign wsrc = wsrc_e'({RF_s1, RF_s0});

    // Reserved source 11 suppresses the write entirely.
    assign rf_w_en = RF_W_wr && (wsrc != WSrcRsvd);

    risc_16bit_regfile #(
        .W (W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .w_en    (rf_w_en),
        .w_addr  (RF_W_addr),
        .w_data  (w_data),
        .rp_addr (RF_Rp_addr),
        .rp_rd   (RF_Rp_rd),
        .rq_addr (RF_Rq_addr),
        .rq_rd   (RF_Rq_rd),
        .rp_data (rp_data),
        .rq_data (rq_data)
    );

    assign RF_Rp_zero = (rp_data == '0);

    assign add_res = rp_data + rq_data;
    assign sub_res = rp_data - rq_data;

    always_comb begin
        alu_out = '0;
        case (alu_op_e'(alu_s))
            AluAdd:   alu_out = add_res;
            AluSub:   alu_out = sub_res;
            AluAnd:   alu_out = rp_data & rq_data;
            AluOr:    alu_out = rp_data | rq_data;
            AluXor:   alu_out = rp_data ^ rq_data;
            AluNot:   alu_out = ~rp_data;
            AluPassA: alu_out = rp_data;
            AluPassB: alu_out = rq_data;
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        w_data = '0;
        case (wsrc)
            WSrcAlu: w_data = alu_out;
            WSrcMem: w_data = R_data;
            WSrcImm: w_data = {{(W-AW){RF_W_data[AW-1]}}, RF_W_data};
            default: w_data = '0;
        endcase
    end

    // Data memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (D_wr) begin
            mem[D_addr] <= rp_data;
        end
    end

    assign R_data = D_rd ? mem[D_addr] : '0;

`ifdef RISC16_DP_FLAGS_EN
    logic flags_upd;
    logic c_d;
    logic v_d;

    always_comb begin
        flags_upd = 1'b0;
        c_d       = 1'b0;
        v_d       = 1'b0;
        if (RF_W_wr && (wsrc == WSrcAlu)) begin
            if (alu_op_e'(alu_s) == AluAdd) begin
                flags_upd = 1'b1;
                c_d = (rp_data[W-1] & rq_data[W-1]) |
                      ((rp_data[W-1] | rq_data[W-1]) & ~add_res[W-1]);
                v_d = (rp_data[W-1] == rq_data[W-1]) && (add_res[W-1] != rp_data[W-1]);
            end else if (alu_op_e'(alu_s) == AluSub) begin
                flags_upd = 1'b1;
                c_d = (rp_data < rq_data);
                v_d = (rp_data[W-1] != rq_data[W-1]) && (sub_res[W-1] != rp_data[W-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (flags_upd) begin
            flag_c <= c_d;
            flag_v <= v_d;
        end
    end
`endif

endmodule
